// File: rtl/lc3_mem_pkg.sv
// lc3_mem_pkg
// Shared definitions for the LC-3 memory responder slice:
//   port_state_t   - per-port handshake state (IDLE / WAIT / RESP)
//   BASE_ADDR      - conventional program load address
//   DEFAULT_MEM_AW - default word-address width of the backing array
//   LAT_CW         - width of the per-port latency counter
//   addr_in_range  - true when the address bits above the array width are zero
package lc3_mem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } port_state_t;

    localparam logic [15:0] BASE_ADDR      = 16'h3000;
    localparam int          DEFAULT_MEM_AW = 16;
    localparam int          LAT_CW         = 4;

    // Bits [15:aw] must all be zero for the word to exist in the array.
    function automatic logic addr_in_range(input logic [15:0] addr, input int aw);
        logic [15:0] hi;
        hi = (aw >= 16) ? 16'h0000 : (addr >> aw);
        return (hi == 16'h0000);
    endfunction

endpackage

// File: rtl/lc3_mem_port_fsm.sv
// lc3_mem_port_fsm
// One request/response port of the memory responder (used for both the
// instruction and the data port).
//
// Handshake: the requester raises req and holds it; the request is accepted
// at the first rising edge where the port is not in WAIT. Dropping req while
// in WAIT aborts the access. complete is high for exactly the one RESP cycle;
// if req is still high during RESP a new request is accepted at that edge.
//
// Ports:
//   clock, reset  - clock, asynchronous active-high reset
//   req           - request level from the requester
//   lat           - wait-cycle count loaded at acceptance
//   state         - current state (port_state_t encoding), for observation
//   commit        - high during the cycle whose closing edge performs the access
//   complete      - registered one-cycle completion pulse (high in RESP)
module lc3_mem_port_fsm
    import lc3_mem_pkg::*;
(
    input  logic              clock,
    input  logic              reset,
    input  logic              req,
    input  logic [LAT_CW-1:0] lat,
    output logic [1:0]        state,
    output logic              commit,
    output logic              complete
);

    port_state_t       state_q;
    logic [LAT_CW-1:0] cnt;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            cnt      <= '0;
            complete <= 1'b0;
        end else begin
            complete <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (req) begin
                        state_q <= WAIT;
                        cnt     <= lat;
                    end
                end
                WAIT: begin
                    // Abort wins over completion: a dropped request never commits.
                    if (!req) begin
                        state_q <= IDLE;
                        cnt     <= '0;
                    end else if (cnt == '0) begin
                        state_q  <= RESP;
                        complete <= 1'b1;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                RESP: begin
                    // Request still high here is a new back-to-back access.
                    if (req) begin
                        state_q <= WAIT;
                        cnt     <= lat;
                    end else begin
                        state_q <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    cnt     <= '0;
                end
            endcase
        end
    end

    assign state  = state_q;
    assign commit = (state_q == WAIT) && req && (cnt == '0);

endmodule

// File: rtl/lc3_mem_responder.sv
// lc3_mem_responder
// Behavioural 16-bit word memory answering an LC-3 core's instruction and
// data ports with configurable wait states, plus a backdoor load port.
//
// Ports:
//   clock, reset                          - clock, asynchronous active-high reset
//   pc, instrmem_rd                       - fetch address / fetch request
//   Instr_dout, complete_instr            - fetch data / fetch done pulse
//   Data_addr, Data_en, Data_rd, Data_din - data request (Data_rd 1=read, 0=write)
//   Data_dout, complete_data              - read data / access done pulse
//   ld_en, ld_addr, ld_data               - backdoor program-load write
//   addr_err                              - sticky out-of-range access flag
//
// Build option: define MEM_STALL_RAND_EN to add 0..3 pseudo-random extra wait
// cycles per accepted request, drawn from a 16-bit Fibonacci LFSR.
module lc3_mem_responder
    import lc3_mem_pkg::*;
#(
    parameter int          INSTR_LAT = 0,
    parameter int          DATA_LAT  = 0,
    parameter int          MEM_AW    = DEFAULT_MEM_AW,
    parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [15:0] pc,
    input  logic        instrmem_rd,
    output logic [15:0] Instr_dout,
    output logic        complete_instr,
    input  logic [15:0] Data_addr,
    input  logic        Data_en,
    input  logic        Data_rd,
    input  logic [15:0] Data_din,
    output logic [15:0] Data_dout,
    output logic        complete_data,
    input  logic        ld_en,
    input  logic [15:0] ld_addr,
    input  logic [15:0] ld_data,
    output logic        addr_err
);

    logic [15:0] mem [0:(1<<MEM_AW)-1];

    logic [1:0]        i_state, d_state;
    logic              i_commit, d_commit;
    logic              i_accept, d_accept;
    logic [LAT_CW-1:0] i_lat, d_lat;

    logic [15:0] i_addr, d_addr, d_din;
    logic        d_rd;

    // Acceptance happens at any edge where the port is not waiting (IDLE or RESP).
    assign i_accept = instrmem_rd && (i_state != WAIT);
    assign d_accept = Data_en     && (d_state != WAIT);

`ifdef MEM_STALL_RAND_EN
    logic [15:0] lfsr, lfsr_1;

    function automatic logic [15:0] lfsr_step(input logic [15:0] s);
        return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
    endfunction

    // Base latency plus stall, clamped so the counter cannot wrap.
    function automatic logic [LAT_CW-1:0] add_stall(input logic [LAT_CW-1:0] base,
                                                    input logic [1:0] s);
        logic [LAT_CW:0] sum;
        sum = {1'b0, base} + (LAT_CW+1)'(s);
        return sum[LAT_CW] ? '1 : sum[LAT_CW-1:0];
    endfunction

    assign lfsr_1 = lfsr_step(lfsr);
    // Instruction port draws first; the data port takes the next value when
    // both accept on the same edge.
    assign i_lat = add_stall(LAT_CW'(INSTR_LAT), lfsr[1:0]);
    assign d_lat = add_stall(LAT_CW'(DATA_LAT), i_accept ? lfsr_1[1:0] : lfsr[1:0]);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            lfsr <= LFSR_SEED;
        end else if (i_accept && d_accept) begin
            lfsr <= lfsr_step(lfsr_1);
        end else if (i_accept || d_accept) begin
            lfsr <= lfsr_1;
        end
    end
`else
    assign i_lat = LAT_CW'(INSTR_LAT);
    assign d_lat = LAT_CW'(DATA_LAT);
`endif

    lc3_mem_port_fsm u_instr_port (
        .clock    (clock),
        .reset    (reset),
        .req      (instrmem_rd),
        .lat      (i_lat),
        .state    (i_state),
        .commit   (i_commit),
        .complete (complete_instr)
    );

    lc3_mem_port_fsm u_data_port (
        .clock    (clock),
        .reset    (reset),
        .req      (Data_en),
        .lat      (d_lat),
        .state    (d_state),
        .commit   (d_commit),
        .complete (complete_data)
    );

    // Request attributes are captured at acceptance; later input changes are ignored.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            i_addr <= 16'h0000;
            d_addr <= 16'h0000;
            d_rd   <= 1'b0;
            d_din  <= 16'h0000;
        end else begin
            if (i_accept) begin
                i_addr <= pc;
            end
            if (d_accept) begin
                d_addr <= Data_addr;
                d_rd   <= Data_rd;
                d_din  <= Data_din;
            end
        end
    end

    logic              i_ok, d_ok, ld_ok;
    logic [MEM_AW-1:0] i_idx, d_idx, ld_idx;

    assign i_ok   = addr_in_range(i_addr, MEM_AW);
    assign d_ok   = addr_in_range(d_addr, MEM_AW);
    assign ld_ok  = addr_in_range(ld_addr, MEM_AW);
    assign i_idx  = i_addr[MEM_AW-1:0];
    assign d_idx  = d_addr[MEM_AW-1:0];
    assign ld_idx = ld_addr[MEM_AW-1:0];

    // Read data is sampled at the commit edge, so a same-edge write is not
    // visible (read-before-write). Out-of-range reads return zero.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            Instr_dout <= 16'h0000;
            Data_dout  <= 16'h0000;
            addr_err   <= 1'b0;
        end else begin
            if (i_commit) begin
                Instr_dout <= i_ok ? mem[i_idx] : 16'h0000;
                if (!i_ok) begin
                    addr_err <= 1'b1;
                end
            end
            if (d_commit) begin
                if (d_rd) begin
                    Data_dout <= d_ok ? mem[d_idx] : 16'h0000;
                end
                if (!d_ok) begin
                    addr_err <= 1'b1;
                end
            end
        end
    end

    // The array itself is never reset. The load port wins a same-word collision.
    always_ff @(posedge clock) begin
        if (d_commit && !d_rd && d_ok && !(ld_en && ld_ok && (ld_idx == d_idx))) begin
            mem[d_idx] <= d_din;
        end
        if (ld_en && ld_ok) begin
            mem[ld_idx] <= ld_data;
        end
    end

endmodule

// File: tb/tb_lc3_mem_responder.sv
`timescale 1ns/1ps
module tb_lc3_mem_responder;
    import lc3_mem_pkg::*;

    localparam int          A_ILAT = 0;
    localparam int          A_DLAT = 3;
    localparam logic [15:0] SEED   = 16'hACE1;

    // ---------------- clock / reset ----------------
    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    // ---------------- DUT A (full 64K array) ----------------
    logic [15:0] pc = '0, Data_addr = '0, Data_din = '0, ld_addr = '0, ld_data = '0;
    logic        instrmem_rd = 1'b0, Data_en = 1'b0, Data_rd = 1'b0, ld_en = 1'b0;
    logic [15:0] Instr_dout, Data_dout;
    logic        complete_instr, complete_data, addr_err;

    lc3_mem_responder #(.INSTR_LAT(A_ILAT), .DATA_LAT(A_DLAT), .MEM_AW(16), .LFSR_SEED(SEED)) dut_a (
        .clock(clock), .reset(reset),
        .pc(pc), .instrmem_rd(instrmem_rd), .Instr_dout(Instr_dout), .complete_instr(complete_instr),
        .Data_addr(Data_addr), .Data_en(Data_en), .Data_rd(Data_rd), .Data_din(Data_din),
        .Data_dout(Data_dout), .complete_data(complete_data),
        .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data), .addr_err(addr_err)
    );

    // ---------------- DUT B (4K array, for range errors) ----------------
    logic [15:0] b_pc = '0, b_Data_addr = '0, b_Data_din = '0, b_ld_addr = '0, b_ld_data = '0;
    logic        b_instrmem_rd = 1'b0, b_Data_en = 1'b0, b_Data_rd = 1'b1, b_ld_en = 1'b0;
    logic [15:0] b_Instr_dout, b_Data_dout;
    logic        b_complete_instr, b_complete_data, b_addr_err;

    lc3_mem_responder #(.INSTR_LAT(0), .DATA_LAT(0), .MEM_AW(12), .LFSR_SEED(SEED)) dut_b (
        .clock(clock), .reset(reset),
        .pc(b_pc), .instrmem_rd(b_instrmem_rd), .Instr_dout(b_Instr_dout), .complete_instr(b_complete_instr),
        .Data_addr(b_Data_addr), .Data_en(b_Data_en), .Data_rd(b_Data_rd), .Data_din(b_Data_din),
        .Data_dout(b_Data_dout), .complete_data(b_complete_data),
        .ld_en(b_ld_en), .ld_addr(b_ld_addr), .ld_data(b_ld_data), .addr_err(b_addr_err)
    );

    int tests_run    = 0;
    int tests_failed = 0;

    // ---------------- reference model ----------------
    logic [15:0] ref_lfsr = SEED;
    logic [15:0] exp_q[$];

    function automatic logic [15:0] model_lfsr_next(input logic [15:0] s);
        return {s[14:0], ^(s & 16'hB400)};
    endfunction

    // Cycles from the accept edge (counted as 1) to the edge after which
    // complete is visible: one per wait cycle plus the accept and response edges.
    task automatic predict_latency(input int base, output int lat);
        int extra;
        extra = 0;
`ifdef MEM_STALL_RAND_EN
        extra = int'(ref_lfsr[1:0]);
`endif
        ref_lfsr = model_lfsr_next(ref_lfsr);
        lat = base + extra + 2;
    endtask

    // ---------------- driver tasks (entered and left at a negedge) ----------------
    task automatic apply_reset();
        @(negedge clock);
        reset = 1'b1;
        repeat (2) @(negedge clock);
        reset = 1'b0;
        ref_lfsr = SEED;
    endtask

    task automatic do_ld(input logic [15:0] a, input logic [15:0] d);
        ld_en = 1'b1; ld_addr = a; ld_data = d;
        @(negedge clock);
        ld_en = 1'b0;
    endtask

    task automatic data_access(input logic [15:0] a, input logic rd, input logic [15:0] din,
                               output logic [15:0] dout, output int n, output bit seen,
                               output logic after);
        Data_en = 1'b1; Data_addr = a; Data_rd = rd; Data_din = din;
        n = 0; seen = 1'b0; dout = '0;
        while (!seen && n < 40) begin
            @(posedge clock); n++;
            @(negedge clock);
            if (n == 1) begin
                Data_addr = 16'($urandom); Data_din = 16'($urandom); Data_rd = ~rd;
            end
            if (complete_data) begin
                seen = 1'b1; dout = Data_dout;
            end
        end
        Data_en = 1'b0;
        @(negedge clock);
        after = complete_data;
    endtask

    task automatic fetch(input logic [15:0] a, output logic [15:0] dout, output int n,
                         output bit seen, output logic after);
        instrmem_rd = 1'b1; pc = a;
        n = 0; seen = 1'b0; dout = '0;
        while (!seen && n < 40) begin
            @(posedge clock); n++;
            @(negedge clock);
            if (n == 1) pc = 16'($urandom);
            if (complete_instr) begin
                seen = 1'b1; dout = Instr_dout;
            end
        end
        instrmem_rd = 1'b0;
        @(negedge clock);
        after = complete_instr;
    endtask

    task automatic b_read(input logic [15:0] a, output logic [15:0] dout, output bit seen);
        b_Data_en = 1'b1; b_Data_addr = a; b_Data_rd = 1'b1;
        seen = 1'b0; dout = '0;
        for (int k = 0; k < 40 && !seen; k++) begin
            @(posedge clock);
            @(negedge clock);
            if (b_complete_data) begin
                seen = 1'b1; dout = b_Data_dout;
            end
        end
        b_Data_en = 1'b0;
        @(negedge clock);
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        apply_reset();
        tests_run++; if (Instr_dout !== 16'h0000) begin tests_failed++; $display("FAIL reset_instr_dout: got %h expected 0000", Instr_dout); end
        tests_run++; if (Data_dout !== 16'h0000) begin tests_failed++; $display("FAIL reset_data_dout: got %h expected 0000", Data_dout); end
        tests_run++; if (complete_instr !== 1'b0) begin tests_failed++; $display("FAIL reset_complete_instr: got %b expected 0", complete_instr); end
        tests_run++; if (complete_data !== 1'b0) begin tests_failed++; $display("FAIL reset_complete_data: got %b expected 0", complete_data); end
        tests_run++; if (addr_err !== 1'b0) begin tests_failed++; $display("FAIL reset_addr_err: got %b expected 0", addr_err); end
        tests_run++; if (b_addr_err !== 1'b0) begin tests_failed++; $display("FAIL reset_b_addr_err: got %b expected 0", b_addr_err); end
    endtask

    task automatic test_fetch();
        logic [15:0] d; int n, e; bit seen; logic after;
        do_ld(BASE_ADDR, 16'h1021);
        predict_latency(A_ILAT, e);
        fetch(BASE_ADDR, d, n, seen, after);
        tests_run++; if (!seen) begin tests_failed++; $display("FAIL fetch_complete: got none expected pulse"); end
        tests_run++; if (n != e) begin tests_failed++; $display("FAIL fetch_latency: got %0d expected %0d", n, e); end
        tests_run++; if (d !== 16'h1021) begin tests_failed++; $display("FAIL fetch_data: got %h expected 1021", d); end
        tests_run++; if (after !== 1'b0) begin tests_failed++; $display("FAIL fetch_one_cycle: got %b expected 0", after); end
    endtask

    task automatic test_data_latency();
        logic [15:0] d; int n, e; bit seen; logic after;
        do_ld(16'h4001, 16'h6A6A);
        predict_latency(A_DLAT, e);
        data_access(16'h4001, 1'b1, 16'h0, d, n, seen, after);
        tests_run++; if (d !== 16'h6A6A) begin tests_failed++; $display("FAIL dlat_pre_read: got %h expected 6a6a", d); end
        predict_latency(A_DLAT, e);
        data_access(16'h4000, 1'b0, 16'hBEEF, d, n, seen, after);
        tests_run++; if (!seen || n != e) begin tests_failed++; $display("FAIL dlat_write_latency: got %0d expected %0d", n, e); end
        tests_run++; if (d !== 16'h6A6A) begin tests_failed++; $display("FAIL dlat_write_dout_held: got %h expected 6a6a", d); end
        tests_run++; if (after !== 1'b0) begin tests_failed++; $display("FAIL dlat_one_cycle: got %b expected 0", after); end
        predict_latency(A_DLAT, e);
        data_access(16'h4000, 1'b1, 16'h0, d, n, seen, after);
        tests_run++; if (!seen || n != e) begin tests_failed++; $display("FAIL dlat_read_latency: got %0d expected %0d", n, e); end
        tests_run++; if (d !== 16'hBEEF) begin tests_failed++; $display("FAIL dlat_read_data: got %h expected beef", d); end
    endtask

    task automatic test_addr_err();
        logic [15:0] d; bit seen;
        b_ld_en = 1'b1; b_ld_addr = 16'h0123; b_ld_data = 16'hABCD;
        @(negedge clock);
        b_ld_en = 1'b0;
        b_read(16'h0123, d, seen);
        tests_run++; if (d !== 16'hABCD) begin tests_failed++; $display("FAIL aerr_inrange_data: got %h expected abcd", d); end
        tests_run++; if (b_addr_err !== 1'b0) begin tests_failed++; $display("FAIL aerr_inrange_flag: got %b expected 0", b_addr_err); end
        b_read(16'h3000, d, seen);
        tests_run++; if (!seen) begin tests_failed++; $display("FAIL aerr_complete: got none expected pulse"); end
        tests_run++; if (d !== 16'h0000) begin tests_failed++; $display("FAIL aerr_data: got %h expected 0000", d); end
        repeat (5) @(negedge clock);
        tests_run++; if (b_addr_err !== 1'b1) begin tests_failed++; $display("FAIL aerr_sticky: got %b expected 1", b_addr_err); end
        apply_reset();
        tests_run++; if (b_addr_err !== 1'b0) begin tests_failed++; $display("FAIL aerr_cleared: got %b expected 0", b_addr_err); end
    endtask

    task automatic test_read_before_write();
        int dn, in_n, off, k, d_at, i_at, n, e; logic [15:0] iv, d; bit seen; logic after;
        apply_reset();
        do_ld(16'h3002, 16'h0000);
        predict_latency(A_DLAT, dn);
        predict_latency(A_ILAT, in_n);
        off = dn - in_n;
        tests_run++; if (off <= 0) begin tests_failed++; $display("FAIL rbw_setup: got offset %0d expected >0", off); end
        Data_en = 1'b1; Data_addr = 16'h3002; Data_rd = 1'b0; Data_din = 16'h5555;
        k = 0; d_at = -1; i_at = -1; iv = 16'hFFFF;
        while ((d_at < 0 || i_at < 0) && k < 40) begin
            if (k == off) begin instrmem_rd = 1'b1; pc = 16'h3002; end
            @(posedge clock); k++;
            @(negedge clock);
            if (complete_data && d_at < 0) begin d_at = k; Data_en = 1'b0; end
            if (complete_instr && i_at < 0) begin i_at = k; iv = Instr_dout; instrmem_rd = 1'b0; end
        end
        Data_en = 1'b0; instrmem_rd = 1'b0;
        @(negedge clock);
        tests_run++; if (d_at != dn || i_at != dn) begin tests_failed++; $display("FAIL rbw_same_edge: got data %0d instr %0d expected %0d", d_at, i_at, dn); end
        tests_run++; if (iv !== 16'h0000) begin tests_failed++; $display("FAIL rbw_old_value: got %h expected 0000", iv); end
        predict_latency(A_DLAT, e);
        data_access(16'h3002, 1'b1, 16'h0, d, n, seen, after);
        tests_run++; if (d !== 16'h5555) begin tests_failed++; $display("FAIL rbw_new_value: got %h expected 5555", d); end
    endtask

    task automatic test_ld_priority();
        int n, e, k; bit seen; logic [15:0] d; logic after;
        do_ld(16'h3300, 16'h0000);
        predict_latency(A_DLAT, e);
        Data_en = 1'b1; Data_addr = 16'h3300; Data_rd = 1'b0; Data_din = 16'h1111;
        k = 0; seen = 1'b0;
        while (!seen && k < 40) begin
            @(posedge clock); k++;
            @(negedge clock);
            ld_en = (k == e - 1); ld_addr = 16'h3300; ld_data = 16'h2222;
            if (complete_data) begin seen = 1'b1; Data_en = 1'b0; end
        end
        ld_en = 1'b0; Data_en = 1'b0;
        @(negedge clock);
        tests_run++; if (!seen || k != e) begin tests_failed++; $display("FAIL ldpri_latency: got %0d expected %0d", k, e); end
        predict_latency(A_DLAT, n);
        data_access(16'h3300, 1'b1, 16'h0, d, n, seen, after);
        tests_run++; if (d !== 16'h2222) begin tests_failed++; $display("FAIL ldpri_winner: got %h expected 2222", d); end
    endtask

    task automatic test_reset_mid_wait();
        logic [15:0] d; int n, e; bit seen; logic after;
        do_ld(16'h3010, 16'h7777);
        predict_latency(A_ILAT, e);
        fetch(BASE_ADDR, d, n, seen, after);
        predict_latency(A_DLAT, e);
        data_access(16'h3010, 1'b1, 16'h0, d, n, seen, after);
        tests_run++; if (d !== 16'h7777 || Instr_dout !== 16'h1021) begin tests_failed++; $display("FAIL rmw_preload: got %h/%h expected 7777/1021", d, Instr_dout); end
        Data_en = 1'b1; Data_addr = 16'h3010; Data_rd = 1'b0; Data_din = 16'h1234;
        @(posedge clock); @(negedge clock);
        @(posedge clock); @(negedge clock);
        reset = 1'b1;
        #1;
        tests_run++; if (Instr_dout !== 16'h0000 || Data_dout !== 16'h0000) begin tests_failed++; $display("FAIL rmw_douts: got %h/%h expected 0000/0000", Instr_dout, Data_dout); end
        tests_run++; if ({complete_instr, complete_data, addr_err} !== 3'b000) begin tests_failed++; $display("FAIL rmw_flags: got %b expected 000", {complete_instr, complete_data, addr_err}); end
        Data_en = 1'b0;
        @(negedge clock);
        reset = 1'b0;
        ref_lfsr = SEED;
        predict_latency(A_DLAT, e);
        data_access(16'h3010, 1'b1, 16'h0, d, n, seen, after);
        tests_run++; if (d !== 16'h7777) begin tests_failed++; $display("FAIL rmw_kept: got %h expected 7777", d); end
    endtask

    task automatic test_back_to_back();
        int e, k; bit seen; logic [15:0] got;
        apply_reset();
        for (int i = 0; i < 8; i++) begin
            exp_q.push_back(16'($urandom));
            do_ld(16'h3100 + 16'(i), exp_q[i]);
        end
        instrmem_rd = 1'b1; pc = 16'h3100;
        for (int i = 0; i < 8; i++) begin
            predict_latency(A_ILAT, e);
            k = 0; seen = 1'b0; got = '0;
            while (!seen && k < 40) begin
                @(posedge clock); k++;
                @(negedge clock);
                if (k == 1) pc = 16'($urandom);
                if (complete_instr) begin seen = 1'b1; got = Instr_dout; end
            end
            tests_run++; if (!seen || k != e) begin tests_failed++; $display("FAIL b2b_latency[%0d]: got %0d expected %0d", i, k, e); end
            tests_run++; if (got !== exp_q[i]) begin tests_failed++; $display("FAIL b2b_data[%0d]: got %h expected %h", i, got, exp_q[i]); end
            if (!seen) break;
            if (i < 7) pc = 16'h3101 + 16'(i);
            else instrmem_rd = 1'b0;
        end
        instrmem_rd = 1'b0;
        @(negedge clock);
        exp_q.delete();
    endtask

    task automatic test_random();
        logic [15:0] win [16];
        logic [15:0] d, din, last_rd;
        int n, e, op, idx, cnt; bit seen; logic after;
        for (int i = 0; i < 16; i++) begin
            win[i] = 16'($urandom);
            do_ld(16'h3200 + 16'(i), win[i]);
        end
        last_rd = '0;
        for (int t = 0; t < 30; t++) begin
            op  = (t == 0) ? 0 : $urandom_range(0, 3);
            idx = $urandom_range(0, 15);
            din = 16'($urandom);
            predict_latency(A_DLAT, e);
            if (op <= 1) begin
                data_access(16'h3200 + 16'(idx), 1'b1, 16'h0, d, n, seen, after);
                tests_run++; if (!seen || n != e || d !== win[idx]) begin tests_failed++; $display("FAIL rnd_read[%0d]: got %h lat %0d expected %h lat %0d", t, d, n, win[idx], e); end
                last_rd = win[idx];
            end else if (op == 2) begin
                data_access(16'h3200 + 16'(idx), 1'b0, din, d, n, seen, after);
                tests_run++; if (!seen || n != e || d !== last_rd) begin tests_failed++; $display("FAIL rnd_write[%0d]: got dout %h lat %0d expected %h lat %0d", t, d, n, last_rd, e); end
                win[idx] = din;
            end else begin
                Data_en = 1'b1; Data_addr = 16'h3200 + 16'(idx); Data_rd = 1'b0; Data_din = din;
                @(posedge clock); @(negedge clock);
                Data_en = 1'b0;
                cnt = 0;
                repeat (6) begin
                    @(posedge clock); @(negedge clock);
                    if (complete_data) cnt++;
                end
                tests_run++; if (cnt != 0) begin tests_failed++; $display("FAIL rnd_abort[%0d]: got %0d completes expected 0", t, cnt); end
            end
        end
    endtask

    // ---------------- main sequence and report ----------------
    initial begin
        test_reset();
        test_fetch();
        test_data_latency();
        test_addr_err();
        test_read_before_write();
        test_ld_priority();
        test_reset_mid_wait();
        test_back_to_back();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

endmodule
